// File: rtl/risc_pkg.sv
// Shared RISC-V front-end definitions: opcode constants, the fetch word and the
// issue controller state, plus helpers that say which source registers an opcode reads.
package risc_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetchWord_t;

  typedef enum logic [0:0] {RUN, FLUSH} state_t;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    logic used;
    case (opcode)
      LUI, AUIPC, JAL: used = 1'b0;
      default:         used = 1'b1;
    endcase
    return used;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    logic used;
    case (opcode)
      OP, STORE, BRANCH: used = 1'b1;
      default:           used = 1'b0;
    endcase
    return used;
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Synchronous FIFO of fetch words. The head word reads as zero while the queue is empty;
// clear drops all entries and wins over a same-cycle push or pop.
module inst_queue
  import risc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetchWord_t               wdata,
  output fetchWord_t               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetchWord_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = empty ? '0 : mem[rd_ptr_q];

  // Storage needs no reset: the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Issues queued fetch words to the decoder, stalling on load-use hazards against execute
// and dropping queued work on a redirect, after which fetch is held off for FLUSH_CYC cycles.
module decode_issue_ctrl
  import risc_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     fetchValid,
  input  logic [31:0]              fetchInstr,
  input  logic [XLEN-1:0]          fetchPc,
  output logic                     fetchReady,
  output logic                     decValid,
  output logic [31:0]              decInstr,
  output logic [XLEN-1:0]          decPc,
  input  logic                     decReady,
  input  logic                     exIsLoad,
  input  logic [4:0]               exRdAddr,
  input  logic                     flush,
  output logic [CNT_W-1:0]         bubbleCnt,
  output logic [$clog2(DEPTH):0]   qLevel
);

  localparam int unsigned CW = $clog2(FLUSH_CYC + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  fetchWord_t q_wdata, q_head;
  logic       q_full, q_empty, q_push, q_pop;
  logic       running, hazard;
  logic [6:0] head_op;
  logic [4:0] head_rs1, head_rs2;

  assign q_wdata = '{instr: fetchInstr, pc: fetchPc};

  inst_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rstn  (rstn),
    .push  (q_push),
    .pop   (q_pop),
    .clear (flush),
    .wdata (q_wdata),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .level (qLevel)
  );

  assign head_op  = q_head.instr[6:0];
  assign head_rs1 = q_head.instr[19:15];
  assign head_rs2 = q_head.instr[24:20];

  // Only the head is checked; a word behind it cannot issue before it anyway.
  assign hazard = exIsLoad && (exRdAddr != 5'd0) && !q_empty &&
                  ((uses_rs1(head_op) && (head_rs1 == exRdAddr)) ||
                   (uses_rs2(head_op) && (head_rs2 == exRdAddr)));

  assign running    = (state_q == RUN) && !flush;
  assign fetchReady = !q_full && running;
  assign decValid   = !q_empty && !hazard && running;
  assign decInstr   = q_head.instr;
  assign decPc      = q_head.pc;
  assign q_push     = fetchValid && fetchReady;
  assign q_pop      = decValid && decReady;
  assign bubbleCnt  = bubble_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (flush) begin
          state_d = FLUSH;
          cnt_d   = CW'(FLUSH_CYC);
        end
      end
      FLUSH: begin
        if (flush) begin
          cnt_d = CW'(FLUSH_CYC);
        end else if (cnt_q == CW'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    bubble_d = bubble_q;
    if (hazard && running && (bubble_q != '1)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bubble_q <= bubble_d;
    end
  end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Sequences instructions from the fetch stage into the instruction decoder.
- Buffers fetched instructions in a small queue and presents the head instruction to the decoder with a valid/ready handshake.
- Inserts bubbles on load-use hazards against the instruction in execute.
- Drops queued work on a branch/jump flush, then holds fetch off for a fixed redirect window.

Parameters:
XLEN, 32, width of the PC.
DEPTH, 4, queue entries; power of 2, at least 2.
FLUSH_CYC, 2, cycles fetchReady is held low after a flush; at least 1.
CNT_W, 16, width of the bubble counter.

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  reset, asynchronous, active-low.
fetchValid  in  1  fetch presents an instruction.
fetchInstr  in  32  fetched instruction word.
fetchPc  in  XLEN  PC of fetchInstr.
fetchReady  out  1  controller accepts the fetch word this cycle.
decValid  out  1  decoder input is valid.
decInstr  out  32  instruction to the decoder.
decPc  out  XLEN  PC to the decoder.
decReady  in  1  decoder accepts this cycle.
exIsLoad  in  1  instruction in execute is a load.
exRdAddr  in  5  destination register of the instruction in execute.
flush  in  1  branch/jump redirect, single-cycle pulse.
bubbleCnt  out  CNT_W  saturating count of hazard bubble cycles.
qLevel  out  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (rstn=0, asynchronous): queue empty, state RUN, flush counter 0, bubbleCnt 0, qLevel 0. Therefore fetchReady=1, decValid=0, decInstr=0, decPc=0.
- Push: fetchValid && fetchReady.
- Pop: decValid && decReady.
- fetchReady = !full && state==RUN && !flush. No push when the queue is full, even if a pop happens in the same cycle.
- Latency: a word pushed in cycle N with the queue empty gives decValid=1 in cycle N+1.
- decInstr/decPc come straight from the queue head. When the queue is empty they are held at 0.
- Push and pop in the same cycle leave qLevel unchanged.
- Pointers wrap modulo DEPTH. qLevel ranges 0..DEPTH.

Hazard detection (head instruction only):
- Source use by opcode (bits 6:0):
  - rs1 (bits 19:15) is used by every opcode except LUI, AUIPC and JAL.
  - rs2 (bits 24:20) is used only by OP, STORE and BRANCH.
- hazard = exIsLoad && exRdAddr!=0 && !empty && (used rs1==exRdAddr || used rs2==exRdAddr).
- decValid = !empty && !hazard && state==RUN && !flush.
- Each cycle with hazard && state==RUN && !flush increments bubbleCnt, saturating at all-ones.

State machine:
- RUN: on flush, go to FLUSH. Clear the queue (qLevel=0 next cycle), drop any same-cycle fetch word, do not pop, and load cnt=FLUSH_CYC.
- FLUSH: fetchReady=0 and decValid=0. cnt decrements each cycle; when cnt==1, return to RUN.
- flush asserted while in FLUSH clears the queue and reloads cnt=FLUSH_CYC.
- Flush coinciding with a decoder handshake: decValid is forced to 0, so no pop occurs.
- Reset mid-operation returns immediately to the reset values and discards the queue.

Decomposition:
- Shared package risc_pkg: XLEN, opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM), and a typedef struct fetchWord_t {instr, pc}.
- State enum {RUN, FLUSH} lives in the package.
- One sub-module: inst_queue, a synchronous FIFO of fetchWord_t with push, pop, full, empty and level, using the same clk and rstn.
- The hazard check and the FSM stay in decode_issue_ctrl.

Test Plan:
- Reset then push ADDI 0x00500093 at PC 0x0 with decReady=1 -> decValid=1 next cycle; decInstr=0x00500093, decPc=0x0; qLevel returns to 0.
- Hold decReady=0 and push 5 words -> fetchReady drops after 4 pushes, qLevel=4. Then decReady=1 -> words are popped in PC order 0x0, 0x4, 0x8, 0xC, then the 5th word is accepted.
- exIsLoad=1, exRdAddr=1, head ADD x3,x1,x2 (0x002081B3) held 3 cycles -> decValid=0 for those 3 cycles, bubbleCnt=3. Release -> issues the next cycle.
- Same as above with head LUI x1 (0x000010B7) -> no bubble; exRdAddr=0 with a matching rs field -> no bubble.
- Queue holding 3 entries, flush pulse with FLUSH_CYC=2 -> qLevel=0 next cycle, fetchReady=0 for 2 cycles then 1, and none of the dropped words ever appear on the decoder side.
- Assert rstn=0 asynchronously mid-burst -> all outputs at reset values before the next clock edge.
